// File: rtl/router_pkg.sv
// Shared types and constants for the N-channel router controller FSM.
package router_pkg;

  typedef enum logic [3:0] {
    ST_DECODE_ADDRESS     = 4'd0,
    ST_WAIT_TILL_EMPTY    = 4'd1,
    ST_LOAD_FIRST_DATA    = 4'd2,
    ST_LOAD_DATA          = 4'd3,
    ST_FIFO_FULL_STATE    = 4'd4,
    ST_LOAD_AFTER_FULL    = 4'd5,
    ST_LOAD_PARITY        = 4'd6,
    ST_CHECK_PARITY_ERROR = 4'd7,
    ST_DROP_PACKET        = 4'd8
  } router_state_t;

  localparam int MIN_ADDR_W = 1;
  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Header address width for a given channel count, never narrower than one bit.
  function automatic int addr_w_for(input int num_ch);
    return (num_ch <= 2) ? MIN_ADDR_W : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/router_fsm_n_if.sv
// Control/status bundle between the router FSM (slave) and its register/FIFO surroundings (master).
interface router_fsm_n_if
  import router_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = addr_w_for(NUM_CH),
  parameter int DATA_W = 8
);

  logic                  pkt_valid;
  logic [DATA_W-1:0]     data_in;
  logic                  fifo_full;
  logic [NUM_CH-1:0]     fifo_empty;
  logic [NUM_CH-1:0]     soft_reset;
  logic                  parity_done;
  logic                  low_pkt_valid;

  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  write_enb_reg;
  logic                  rst_int_reg;
  logic                  busy;
  logic                  drop_state;
  logic [ADDR_W-1:0]     sel_ch;
  logic [DROP_CNT_W-1:0] drop_count;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
           rst_int_reg, busy, drop_state, sel_ch, drop_count
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
           rst_int_reg, busy, drop_state, sel_ch, drop_count
  );

endinterface

// File: rtl/router_wait_timer.sv
// Down-counter bounding the time spent waiting for a destination FIFO to drain.
module router_wait_timer #(
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = LOAD_VAL;
    end else if (enable && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= LOAD_VAL;
    else       cnt_q <= cnt_d;
  end

  // Reaching zero means this is wait cycle WAIT_TIMEOUT-1.
  assign expire = enable && (cnt_q == '0);

endmodule

// File: rtl/router_fsm_n.sv
// N-channel packet router controller FSM (Moore decodes, registered destination and drop counter).
// Optional wait-timeout into DROP_PACKET is enabled by defining ROUTER_FSM_TIMEOUT_EN.
module router_fsm_n
  import router_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = addr_w_for(NUM_CH),
  parameter int DATA_W       = 8,
  parameter int WAIT_TIMEOUT = 1024
) (
  input logic           clock,
  input logic           reset,
  router_fsm_n_if.slave bus
);

  router_state_t         state_q, state_d;
  logic [ADDR_W-1:0]     sel_ch_q, sel_ch_d;
  logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
  logic [ADDR_W-1:0]     hdr_addr;
  logic                  hdr_valid;
  logic                  timeout_hit;

  assign hdr_addr  = bus.data_in[ADDR_W-1:0];
  assign hdr_valid = int'(hdr_addr) < NUM_CH;

`ifdef ROUTER_FSM_TIMEOUT_EN
  router_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wait_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != ST_WAIT_TILL_EMPTY),
    .enable (state_q == ST_WAIT_TILL_EMPTY),
    .expire (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    sel_ch_d     = sel_ch_q;
    drop_count_d = drop_count_q;

    case (state_q)
      ST_DECODE_ADDRESS: begin
        if (bus.pkt_valid) begin
          sel_ch_d = hdr_addr;
          if (!hdr_valid)                    state_d = ST_DROP_PACKET;
          else if (bus.fifo_empty[hdr_addr]) state_d = ST_LOAD_FIRST_DATA;
          else                               state_d = ST_WAIT_TILL_EMPTY;
        end
      end
      ST_WAIT_TILL_EMPTY: begin
        if (bus.fifo_empty[sel_ch_q]) state_d = ST_LOAD_FIRST_DATA;
        else if (timeout_hit)         state_d = ST_DROP_PACKET;
      end
      ST_LOAD_FIRST_DATA: state_d = ST_LOAD_DATA;
      ST_LOAD_DATA: begin
        if (bus.fifo_full)       state_d = ST_FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_d = ST_LOAD_PARITY;
      end
      ST_FIFO_FULL_STATE: begin
        if (!bus.fifo_full) state_d = ST_LOAD_AFTER_FULL;
      end
      ST_LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_d = ST_DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_d = ST_LOAD_PARITY;
        else                        state_d = ST_LOAD_DATA;
      end
      ST_LOAD_PARITY: state_d = ST_CHECK_PARITY_ERROR;
      ST_CHECK_PARITY_ERROR: begin
        state_d = bus.fifo_full ? ST_FIFO_FULL_STATE : ST_DECODE_ADDRESS;
      end
      ST_DROP_PACKET: begin
        if (!bus.pkt_valid) state_d = ST_DECODE_ADDRESS;
      end
      default: state_d = ST_DECODE_ADDRESS;
    endcase

    // Soft reset of the routed channel overrides the normal transition.
    if (state_q != ST_DECODE_ADDRESS && state_q != ST_DROP_PACKET &&
        bus.soft_reset[sel_ch_q]) begin
      state_d = ST_DECODE_ADDRESS;
    end

    if (state_d == ST_DROP_PACKET && state_q != ST_DROP_PACKET &&
        drop_count_q != DROP_CNT_MAX) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q      <= ST_DECODE_ADDRESS;
      sel_ch_q     <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_ch_q     <= sel_ch_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bus.detect_add    = (state_q == ST_DECODE_ADDRESS);
  assign bus.lfd_state     = (state_q == ST_LOAD_FIRST_DATA);
  assign bus.ld_state      = (state_q == ST_LOAD_DATA);
  assign bus.laf_state     = (state_q == ST_LOAD_AFTER_FULL);
  assign bus.full_state    = (state_q == ST_FIFO_FULL_STATE);
  assign bus.rst_int_reg   = (state_q == ST_CHECK_PARITY_ERROR);
  assign bus.drop_state    = (state_q == ST_DROP_PACKET);
  assign bus.write_enb_reg = (state_q == ST_LOAD_DATA) || (state_q == ST_LOAD_AFTER_FULL) ||
                             (state_q == ST_LOAD_PARITY);
  assign bus.busy          = !((state_q == ST_DECODE_ADDRESS) || (state_q == ST_LOAD_DATA) ||
                               (state_q == ST_DROP_PACKET));
  assign bus.sel_ch        = sel_ch_q;
  assign bus.drop_count    = drop_count_q;

endmodule

// File: tb/tb_router_fsm_n.sv
// Directed bench for router_fsm_n: per-cycle compare against a behavioural model plus literal checks.
module tb_router_fsm_n;

  localparam int NUM_CH = 3;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 8;
  localparam int WAIT_TIMEOUT = 16;
`ifdef ROUTER_FSM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Model phases named after the specification's states.
  localparam int M_DEC = 0, M_WAIT = 1, M_LFD = 2, M_LD = 3, M_FULL = 4,
                 M_LAF = 5, M_LP = 6, M_CPE = 7, M_DROP = 8;

  logic clock;
  logic reset;
  router_fsm_n_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  router_fsm_n #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_st = M_DEC;
  int m_sel = 0;
  int m_drops = 0;
  int m_wait = 0;   // completed cycles in the current wait

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_st = M_DEC; m_sel = 0; m_drops = 0; m_wait = 0;
    end else begin
      int nxt;
      int a;
      a = int'(bus.data_in) % (1 << ADDR_W);
      nxt = m_st;
      case (m_st)
        M_DEC:  if (bus.pkt_valid) begin
                  if (a >= NUM_CH)          nxt = M_DROP;
                  else if (bus.fifo_empty[a]) nxt = M_LFD;
                  else                      nxt = M_WAIT;
                end
        M_WAIT: if (bus.fifo_empty[m_sel]) nxt = M_LFD;
                else if (TO_EN && m_wait == WAIT_TIMEOUT - 1) nxt = M_DROP;
        M_LFD:  nxt = M_LD;
        M_LD:   if (bus.fifo_full) nxt = M_FULL; else if (!bus.pkt_valid) nxt = M_LP;
        M_FULL: if (!bus.fifo_full) nxt = M_LAF;
        M_LAF:  nxt = bus.parity_done ? M_DEC : (bus.low_pkt_valid ? M_LP : M_LD);
        M_LP:   nxt = M_CPE;
        M_CPE:  nxt = bus.fifo_full ? M_FULL : M_DEC;
        M_DROP: if (!bus.pkt_valid) nxt = M_DEC;
        default: nxt = M_DEC;
      endcase
      if (m_st != M_DEC && m_st != M_DROP) begin
        if (bus.soft_reset[m_sel]) nxt = M_DEC;
      end
      if (m_st == M_DEC && bus.pkt_valid) m_sel = a;
      if (nxt == M_DROP && m_st != M_DROP && m_drops < 255) m_drops++;
      m_wait = (m_st == M_WAIT && nxt == M_WAIT) ? m_wait + 1 : 0;
      m_st = nxt;
    end
  end

  function automatic logic [18:0] pack_dut();
    return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
            bus.write_enb_reg, bus.rst_int_reg, bus.busy, bus.drop_state, bus.sel_ch,
            bus.drop_count};
  endfunction

  function automatic logic [18:0] pack_model();
    logic we, bz;
    we = (m_st == M_LD) || (m_st == M_LAF) || (m_st == M_LP);
    bz = !((m_st == M_DEC) || (m_st == M_LD) || (m_st == M_DROP));
    return {m_st == M_DEC, m_st == M_LFD, m_st == M_LD, m_st == M_LAF, m_st == M_FULL,
            we, m_st == M_CPE, bz, m_st == M_DROP, 2'(m_sel), 8'(m_drops)};
  endfunction

  // ---------------- per-cycle compare and event counters ----------------
  bit cmp_en = 1'b0;
  int we_cnt, ri_cnt, fs_cnt, ds_cnt, wt_cnt;

  always @(negedge clock) begin
    if (cmp_en) begin
      check("cycle_outputs", 32'(pack_dut()), 32'(pack_model()));
      if (bus.write_enb_reg) we_cnt++;
      if (bus.rst_int_reg)   ri_cnt++;
      if (bus.full_state)    fs_cnt++;
      if (bus.drop_state)    ds_cnt++;
      if (bus.busy && !bus.lfd_state && !bus.full_state && !bus.laf_state &&
          !bus.write_enb_reg && !bus.rst_int_reg) wt_cnt++;
    end
  end

  task automatic step(input logic pv, input logic [7:0] din, input logic full,
                      input logic [2:0] emp, input logic [2:0] sr,
                      input logic pd, input logic lpv);
    bus.pkt_valid     = pv;
    bus.data_in       = din;
    bus.fifo_full     = full;
    bus.fifo_empty    = emp;
    bus.soft_reset    = sr;
    bus.parity_done   = pd;
    bus.low_pkt_valid = lpv;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_counts();
    we_cnt = 0; ri_cnt = 0; fs_cnt = 0; ds_cnt = 0; wt_cnt = 0;
  endtask

  initial begin
    reset = 1'b0;
    bus.pkt_valid = 1'b0; bus.data_in = '0; bus.fifo_full = 1'b0; bus.fifo_empty = 3'b111;
    bus.soft_reset = '0; bus.parity_done = 1'b0; bus.low_pkt_valid = 1'b0;
    clear_counts();
    #1 reset = 1'b1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", 32'(pack_dut()), 32'h40000);
    reset = 1'b0;
    step(0, 8'h00, 0, 3'b111, 3'b000, 0, 0);

    // Empty channel: header 0x05 -> channel 1, 4 payload bytes then parity.
    clear_counts();
    step(1, 8'h05, 0, 3'b111, 3'b000, 0, 0);
    check("empty_lfd_after_header", 32'(bus.lfd_state), 32'd1);
    check("empty_sel_ch", 32'(bus.sel_ch), 32'd1);
    step(1, 8'h11, 0, 3'b111, 3'b000, 0, 0);
    step(1, 8'h22, 0, 3'b111, 3'b000, 0, 0);
    step(1, 8'h33, 0, 3'b111, 3'b000, 0, 0);
    step(1, 8'h44, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h5A, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h00, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h00, 0, 3'b111, 3'b000, 0, 0);
    check("empty_write_enb_cycles", 32'(we_cnt), 32'd5);
    check("empty_rst_int_cycles", 32'(ri_cnt), 32'd1);
    check("empty_back_to_decode", 32'(bus.detect_add), 32'd1);

    // Busy channel: destination 2 not empty for 10 cycles.
    step(1, 8'h02, 0, 3'b011, 3'b000, 0, 0);
    check("busy_in_wait", 32'({bus.busy, bus.lfd_state}), 32'b10);
    repeat (9) step(1, 8'h66, 0, 3'b011, 3'b000, 0, 0);
    step(1, 8'h66, 0, 3'b111, 3'b000, 0, 0);
    check("busy_lfd_after_empty", 32'(bus.lfd_state), 32'd1);
    step(1, 8'h77, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h88, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h00, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h00, 0, 3'b111, 3'b000, 0, 0);

    // Full stall: fifo_full in LOAD_DATA, pkt_valid falls during the stall.
    step(1, 8'h00, 0, 3'b111, 3'b000, 0, 0);
    step(1, 8'h10, 0, 3'b111, 3'b000, 0, 0);
    clear_counts();
    step(1, 8'h20, 1, 3'b111, 3'b000, 0, 0);
    repeat (4) step(0, 8'h30, 1, 3'b111, 3'b000, 0, 1);
    step(0, 8'h30, 0, 3'b111, 3'b000, 0, 1);
    check("stall_laf", 32'(bus.laf_state), 32'd1);
    step(0, 8'h30, 0, 3'b111, 3'b000, 0, 1);
    check("stall_load_parity", 32'({bus.write_enb_reg, bus.busy, bus.ld_state, bus.laf_state}),
          32'b1100);
    check("stall_full_cycles", 32'(fs_cnt), 32'd5);
    step(0, 8'h00, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h00, 0, 3'b111, 3'b000, 0, 0);

    // Parity check sees a full FIFO, then completes via parity_done.
    step(1, 8'h01, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h40, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h41, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h00, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h00, 1, 3'b111, 3'b000, 0, 0);
    check("cpe_full_to_full_state", 32'(bus.full_state), 32'd1);
    step(0, 8'h00, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'h00, 0, 3'b111, 3'b000, 1, 0);
    check("laf_parity_done_decode", 32'(bus.detect_add), 32'd1);

    // Invalid address 3 is dropped.
    clear_counts();
    step(1, 8'h03, 0, 3'b111, 3'b000, 0, 0);
    check("drop_entry", 32'({bus.drop_state, bus.busy}), 32'b10);
    check("drop_count_one", 32'(bus.drop_count), 32'd1);
    repeat (3) step(1, 8'h55, 0, 3'b111, 3'b000, 0, 0);
    step(0, 8'hFF, 0, 3'b111, 3'b000, 0, 0);
    check("drop_exit_decode", 32'(bus.detect_add), 32'd1);
    check("drop_no_writes", 32'(we_cnt), 32'd0);
    check("drop_cycles", 32'(ds_cnt), 32'd4);

    // Soft reset selectivity while routing to channel 1.
    step(1, 8'h01, 0, 3'b111, 3'b000, 0, 0);
    step(1, 8'h12, 0, 3'b111, 3'b001, 0, 0);
    check("soft_reset_other_ignored", 32'(bus.ld_state), 32'd1);
    step(1, 8'h13, 0, 3'b111, 3'b010, 0, 0);
    check("soft_reset_own_decode", 32'(bus.detect_add), 32'd1);
    step(0, 8'h00, 0, 3'b111, 3'b000, 0, 0);

    // Destination 2 never empties.
    clear_counts();
    step(1, 8'h02, 0, 3'b011, 3'b000, 0, 0);
    repeat (19) step(1, 8'h99, 0, 3'b011, 3'b000, 0, 0);
`ifdef ROUTER_FSM_TIMEOUT_EN
    check("timeout_wait_cycles", 32'(wt_cnt), 32'd16);
    check("timeout_drop", 32'({bus.drop_state, bus.drop_count}), 32'h102);
`else
    check("no_timeout_wait_cycles", 32'(wt_cnt), 32'd19);
    check("no_timeout_still_waiting", 32'({bus.drop_state, bus.busy, bus.drop_count}), 32'h101);
`endif
    step(0, 8'h00, 0, 3'b011, 3'b100, 0, 0);
    check("wait_exit_decode", 32'(bus.detect_add), 32'd1);

    // Asynchronous reset in the middle of a packet.
    step(1, 8'h02, 0, 3'b111, 3'b000, 0, 0);
    step(1, 8'hAB, 0, 3'b111, 3'b000, 0, 0);
    reset = 1'b1;
    #1;
    check("midpacket_reset", 32'(pack_dut()), 32'h40000);
    @(posedge clock);
    #1 reset = 1'b0;
    step(0, 8'h00, 0, 3'b111, 3'b000, 0, 0);
    check("after_reset_decode", 32'(bus.detect_add), 32'd1);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
